// File: rtl/regfile_read_arbiter.sv
// Two-lane operand-read arbiter for the 2R/1W architectural register file.
// Round-robin grant on over-subscription, write bypass, flush and saturating conflict counter.
module regfile_read_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid0,
    input  logic              req_valid1,
    output logic              req_ready0,
    output logic              req_ready1,
    input  logic [ADDR_W-1:0] rs1_0,
    input  logic [ADDR_W-1:0] rs1_1,
    input  logic [ADDR_W-1:0] rs2_0,
    input  logic [ADDR_W-1:0] rs2_1,
    input  logic              use_rs2_0,
    input  logic              use_rs2_1,
    output logic              rsp_valid0,
    output logic              rsp_valid1,
    output logic [DATA_W-1:0] rsp_op1_0,
    output logic [DATA_W-1:0] rsp_op1_1,
    output logic [DATA_W-1:0] rsp_op2_0,
    output logic [DATA_W-1:0] rsp_op2_1,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              prio,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic [DATA_W-1:0]            regs_q [NREG];
    logic [1:0]                   demand0_c;
    logic [1:0]                   demand1_c;
    logic [2:0]                   demand_c;
    logic                         open_c;
    logic                         over_c;
    logic                         conflict_c;
    logic                         accept0_c;
    logic                         accept1_c;
    logic                         lane1_base_c;
    logic [1:0][ADDR_W-1:0]       port_addr_c;
    logic [1:0][DATA_W-1:0]       port_data_c;
    logic [DATA_W-1:0]            op1_0_c;
    logic [DATA_W-1:0]            op2_0_c;
    logic [DATA_W-1:0]            op1_1_c;
    logic [DATA_W-1:0]            op2_1_c;

    // Demand and grant: the priority lane wins when more than two reads are requested.
    always_comb begin
        demand0_c  = req_valid0 ? (use_rs2_0 ? 2'd2 : 2'd1) : 2'd0;
        demand1_c  = req_valid1 ? (use_rs2_1 ? 2'd2 : 2'd1) : 2'd0;
        demand_c   = 3'(demand0_c) + 3'(demand1_c);
        open_c     = ~reset & ~flush;
        over_c     = demand_c > 3'd2;
        conflict_c = open_c & over_c;
        req_ready0 = open_c & (~over_c | ~prio);
        req_ready1 = open_c & (~over_c | prio);
        accept0_c  = req_valid0 & req_ready0;
        accept1_c  = req_valid1 & req_ready1;
    end

    // Fill the physical read ports: lane 0 first, then lane 1; rs1 before rs2.
    always_comb begin
        port_addr_c  = '0;
        lane1_base_c = accept0_c;
        if (accept0_c) begin
            port_addr_c[0] = rs1_0;
            port_addr_c[1] = rs2_0;
        end
        if (accept1_c) begin
            if (lane1_base_c) begin
                port_addr_c[1] = rs1_1;
            end else begin
                port_addr_c[0] = rs1_1;
                port_addr_c[1] = rs2_1;
            end
        end
        for (int p = 0; p < 2; p++) begin
            port_data_c[p] = (wr_en && (wr_addr == port_addr_c[p])) ? wr_data
                                                                      : regs_q[port_addr_c[p]];
        end
        // Both lanes accepted implies lane 0 used exactly one port, so lane 1 never needs rs2 then.
        op1_0_c = port_data_c[0];
        op2_0_c = use_rs2_0 ? port_data_c[1] : '0;
        op1_1_c = lane1_base_c ? port_data_c[1] : port_data_c[0];
        op2_1_c = use_rs2_1 ? port_data_c[1] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
            prio         <= 1'b0;
            conflict_cnt <= '0;
            rsp_valid0   <= 1'b0;
            rsp_valid1   <= 1'b0;
            rsp_op1_0    <= '0;
            rsp_op2_0    <= '0;
            rsp_op1_1    <= '0;
            rsp_op2_1    <= '0;
        end else begin
            if (wr_en) begin
                regs_q[wr_addr] <= wr_data;
            end
            rsp_valid0 <= accept0_c;
            rsp_valid1 <= accept1_c;
            if (accept0_c) begin
                rsp_op1_0 <= op1_0_c;
                rsp_op2_0 <= op2_0_c;
            end
            if (accept1_c) begin
                rsp_op1_1 <= op1_1_c;
                rsp_op2_1 <= op2_1_c;
            end
            // Blocked lane takes priority next; counter sticks at all-ones.
            if (conflict_c) begin
                prio <= ~prio;
                if (conflict_cnt != '1) begin
                    conflict_cnt <= conflict_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed plus randomized bench for regfile_read_arbiter against a behavioural model.
module tb_regfile_read_arbiter;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        req_valid0, req_valid1, req_ready0, req_ready1;
    logic [2:0]  rs1_0, rs1_1, rs2_0, rs2_1;
    logic        use_rs2_0, use_rs2_1;
    logic        rsp_valid0, rsp_valid1;
    logic [15:0] rsp_op1_0, rsp_op1_1, rsp_op2_0, rsp_op2_1;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        prio;
    logic [15:0] conflict_cnt;

    regfile_read_arbiter #(.DATA_W(16), .NREG(8), .ADDR_W(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid0(req_valid0), .req_valid1(req_valid1),
        .req_ready0(req_ready0), .req_ready1(req_ready1),
        .rs1_0(rs1_0), .rs1_1(rs1_1), .rs2_0(rs2_0), .rs2_1(rs2_1),
        .use_rs2_0(use_rs2_0), .use_rs2_1(use_rs2_1),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_op1_0(rsp_op1_0), .rsp_op1_1(rsp_op1_1),
        .rsp_op2_0(rsp_op2_0), .rsp_op2_1(rsp_op2_1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .prio(prio), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: architectural registers, priority, counter, expected responses.
    logic [15:0] m_regs [8];
    logic        m_prio;
    logic [15:0] m_cnt;
    logic        e_rv0, e_rv1;
    logic [15:0] e_op1_0, e_op2_0, e_op1_1, e_op2_1;
    logic        last_r0, last_r1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] val(input logic [2:0] a);
        return (wr_en && wr_addr == a) ? wr_data : m_regs[a];
    endfunction

    // One clock: check grants before the edge, advance the model, check registered outputs after.
    task automatic cycle();
        int  d0, d1, tot;
        logic er0, er1, a0, a1;
        d0  = req_valid0 ? 1 + int'(use_rs2_0) : 0;
        d1  = req_valid1 ? 1 + int'(use_rs2_1) : 0;
        tot = d0 + d1;
        #1;
        if (reset || flush) begin
            er0 = 1'b0; er1 = 1'b0;
        end else if (tot <= 2) begin
            er0 = 1'b1; er1 = 1'b1;
        end else begin
            er0 = (m_prio == 1'b0); er1 = (m_prio == 1'b1);
        end
        last_r0 = req_ready0;
        last_r1 = req_ready1;
        chk("req_ready0", 32'(req_ready0), 32'(er0));
        chk("req_ready1", 32'(req_ready1), 32'(er1));
        a0 = req_valid0 & er0;
        a1 = req_valid1 & er1;
        if (reset) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_prio = 1'b0; m_cnt = '0;
            e_rv0 = 1'b0; e_rv1 = 1'b0;
            e_op1_0 = '0; e_op2_0 = '0; e_op1_1 = '0; e_op2_1 = '0;
        end else begin
            if (a0) begin
                e_op1_0 = val(rs1_0);
                e_op2_0 = use_rs2_0 ? val(rs2_0) : 16'h0;
            end
            if (a1) begin
                e_op1_1 = val(rs1_1);
                e_op2_1 = use_rs2_1 ? val(rs2_1) : 16'h0;
            end
            e_rv0 = a0;
            e_rv1 = a1;
            if (!flush && tot > 2) begin
                m_prio = er0 ? 1'b1 : 1'b0;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            if (wr_en) m_regs[wr_addr] = wr_data;
        end
        @(posedge clk);
        #1;
        chk("rsp_valid0", 32'(rsp_valid0), 32'(e_rv0));
        chk("rsp_valid1", 32'(rsp_valid1), 32'(e_rv1));
        chk("rsp_op1_0", 32'(rsp_op1_0), 32'(e_op1_0));
        chk("rsp_op2_0", 32'(rsp_op2_0), 32'(e_op2_0));
        chk("rsp_op1_1", 32'(rsp_op1_1), 32'(e_op1_1));
        chk("rsp_op2_1", 32'(rsp_op2_1), 32'(e_op2_1));
        chk("prio", 32'(prio), 32'(m_prio));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    endtask

    task automatic idle();
        reset = 1'b0; flush = 1'b0;
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        use_rs2_0 = 1'b0; use_rs2_1 = 1'b0;
        rs1_0 = '0; rs2_0 = '0; rs1_1 = '0; rs2_1 = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic write(input logic [2:0] a, input logic [15:0] d);
        idle();
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cycle();
    endtask

    initial begin
        int pairs, guard;
        idle();
        foreach (m_regs[i]) m_regs[i] = '0;
        m_prio = 1'b0; m_cnt = '0;
        e_rv0 = 1'b0; e_rv1 = 1'b0;
        e_op1_0 = '0; e_op2_0 = '0; e_op1_1 = '0; e_op2_1 = '0;

        // Reset, with a write presented during reset that must be dropped.
        reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h5555;
        cycle();
        cycle();
        chk("reset_cnt", 32'(conflict_cnt), 32'h0);
        chk("reset_prio", 32'(prio), 32'h0);
        chk("reset_ready0", 32'(last_r0), 32'h0);

        // Simple two-operand read.
        write(3'd3, 16'h1234);
        write(3'd5, 16'h00AA);
        idle();
        req_valid0 = 1'b1; rs1_0 = 3'd3; rs2_0 = 3'd5; use_rs2_0 = 1'b1;
        cycle();
        chk("t1_valid0", 32'(rsp_valid0), 32'h1);
        chk("t1_op1", 32'(rsp_op1_0), 32'h1234);
        chk("t1_op2", 32'(rsp_op2_0), 32'h00AA);
        chk("t1_valid1", 32'(rsp_valid1), 32'h0);

        // Demand-3 conflict with lane 1 held, then priority flips.
        idle();
        req_valid0 = 1'b1; rs1_0 = 3'd3; rs2_0 = 3'd5; use_rs2_0 = 1'b1;
        req_valid1 = 1'b1; rs1_1 = 3'd4;
        cycle();
        chk("t2_ready0", 32'(last_r0), 32'h1);
        chk("t2_ready1", 32'(last_r1), 32'h0);
        chk("t2_prio", 32'(prio), 32'h1);
        chk("t2_cnt", 32'(conflict_cnt), 32'h1);
        cycle();
        chk("t2b_ready0", 32'(last_r0), 32'h0);
        chk("t2b_ready1", 32'(last_r1), 32'h1);
        chk("t2b_op1_1", 32'(rsp_op1_1), 32'h0);
        chk("t2b_cnt", 32'(conflict_cnt), 32'h2);

        // Both lanes in immediate form: full throughput, no conflicts.
        pairs = 0;
        for (int i = 0; i < 10; i++) begin
            idle();
            req_valid0 = 1'b1; rs1_0 = 3'(i);
            req_valid1 = 1'b1; rs1_1 = 3'(i + 1);
            cycle();
            if (rsp_valid0 && rsp_valid1) pairs++;
        end
        chk("t3_pairs", 32'(pairs), 32'd10);
        chk("t3_cnt", 32'(conflict_cnt), 32'h2);

        // Same-cycle write bypass.
        idle();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hBEEF;
        req_valid1 = 1'b1; rs1_1 = 3'd2;
        cycle();
        chk("t4_bypass", 32'(rsp_op1_1), 32'hBEEF);

        // Flush blocks acceptance but not the concurrent write.
        idle();
        flush = 1'b1; wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h0F0F;
        req_valid0 = 1'b1; use_rs2_0 = 1'b1; req_valid1 = 1'b1; use_rs2_1 = 1'b1;
        cycle();
        chk("t5_ready0", 32'(last_r0), 32'h0);
        chk("t5_ready1", 32'(last_r1), 32'h0);
        chk("t5_valid0", 32'(rsp_valid0), 32'h0);
        chk("t5_valid1", 32'(rsp_valid1), 32'h0);
        chk("t5_cnt", 32'(conflict_cnt), 32'h2);
        idle();
        req_valid0 = 1'b1; rs1_0 = 3'd7; rs2_0 = 3'd4; use_rs2_0 = 1'b1;
        cycle();
        chk("t5_r7", 32'(rsp_op1_0), 32'h0F0F);
        chk("t5_r4_dropped", 32'(rsp_op2_0), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 59) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            req_valid0 = 1'($urandom);
            req_valid1 = 1'($urandom);
            use_rs2_0  = 1'($urandom);
            use_rs2_1  = 1'($urandom);
            rs1_0 = 3'($urandom); rs2_0 = 3'($urandom);
            rs1_1 = 3'($urandom); rs2_1 = 3'($urandom);
            wr_en = 1'($urandom); wr_addr = 3'($urandom); wr_data = 16'($urandom);
            cycle();
        end

        // Drive the counter up to 0xFFFE with back-to-back demand-4 conflicts.
        idle();
        req_valid0 = 1'b1; use_rs2_0 = 1'b1; req_valid1 = 1'b1; use_rs2_1 = 1'b1;
        rs1_0 = 3'd1; rs2_0 = 3'd2; rs1_1 = 3'd3; rs2_1 = 3'd4;
        guard = 0;
        while (m_cnt != 16'hFFFE && guard < 70000) begin
            cycle();
            guard++;
        end
        chk("sat_preload", 32'(conflict_cnt), 32'hFFFE);
        cycle();
        cycle();
        chk("sat_top", 32'(conflict_cnt), 32'hFFFF);

        // Reset mid-stream with requests pending.
        reset = 1'b1;
        cycle();
        chk("rst_ready0", 32'(last_r0), 32'h0);
        chk("rst_ready1", 32'(last_r1), 32'h0);
        chk("rst_cnt", 32'(conflict_cnt), 32'h0);
        chk("rst_prio", 32'(prio), 32'h0);
        chk("rst_valid0", 32'(rsp_valid0), 32'h0);
        chk("rst_valid1", 32'(rsp_valid1), 32'h0);
        idle();
        req_valid1 = 1'b1; rs1_1 = 3'd3;
        cycle();
        chk("rst_regs_cleared", 32'(rsp_op1_1), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
